mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit: the producer side of the MEM/WB boundary.

---
 rtl/mem_stage_lsu.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Memory-stage load/store unit, producer side of the MEM/WB boundary.
//   Accepts a load/store from EX/MEM, runs one req/ack transaction on the
//   data-RAM bus, aligns and extends load data, and presents it on
//   dram_rdo_o for MEM/WB. The pipeline is stalled for the whole transaction.
//
// Parameters
//   TIMEOUT        REQ-state cycles without bus_ack_i before abort (1..255)
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   mem_re_i       load request          mem_we_i     store request (wins)
//   mem_size_i     00 byte, 01 half, 1x word
//   mem_unsigned_i zero-extend loads     addr_i       byte address
//   wdata_i        store data
//   stall_o        freeze upstream pipeline registers
//   dram_rdo_o     aligned/extended load data to MEM/WB
//   misalign_o     1-cycle pulse, misaligned access rejected
//   bus_err_o      1-cycle pulse, bus timeout
//   bus_req_o      bus request, held until ack or timeout
//   bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o   registered bus command
//   bus_ack_i      one-cycle completion  bus_rdata_i  read data with ack
//   dbg_state      current FSM state (IDLE=0, REQ=1, DONE=2)
//
// Handshake: bus_req_o rises when the command fields become valid and stays
// high with all command fields stable until the cycle in which bus_ack_i is
// sampled high (or the timeout fires). bus_ack_i outside REQ is ignored.

module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] dram_rdo_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        access, misalign, timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [1:0]  ld_off;
  logic [31:0] shifted, ld_data;

  assign access      = mem_re_i | mem_we_i;
  // Counter holds the number of REQ cycles already completed, so the abort
  // lands on the TIMEOUT-th REQ cycle.
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
  assign dbg_state   = state;

  always_comb begin
    misalign   = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = wdata_i;
    case (mem_size_i)
      2'b00: begin
        be_calc    = 4'b0001 << addr_i[1:0];
        wdata_calc = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misalign   = addr_i[0];
        be_calc    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_calc = {2{wdata_i[15:0]}};
      end
      default: begin
        misalign   = |addr_i[1:0];
      end
    endcase
  end

  // Load extraction uses the size/offset latched when the access was issued.
  always_comb begin
    shifted = bus_rdata_i >> {ld_off, 3'b000};
    case (ld_size)
      2'b00:   ld_data = ld_uns ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = ld_uns ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = bus_rdata_i;
    endcase
  end

  // Next state and stall. stall_o is combinational in IDLE so the pipeline
  // freezes in the same cycle the access is seen.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misalign) begin
          stall_o   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_ack_i || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      dram_rdo_o  <= 32'h0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_be_o    <= 4'h0;
      bus_wdata_o <= 32'h0;
      ld_size     <= 2'b00;
      ld_uns      <= 1'b0;
      ld_off      <= 2'b00;
    end else begin
      state      <= state_nxt;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (access) begin
            if (misalign) begin
              misalign_o <= 1'b1;
              dram_rdo_o <= 32'h0;
            end else begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_we_i;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_be_o    <= be_calc;
              bus_wdata_o <= wdata_calc;
              ld_size     <= mem_size_i;
              ld_uns      <= mem_unsigned_i;
              ld_off      <= addr_i[1:0];
            end
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) dram_rdo_o <= ld_data;
          end else if (timeout_hit) begin
            bus_req_o  <= 1'b0;
            bus_err_o  <= 1'b1;
            dram_rdo_o <= 32'h0;
          end
        end
        default: cnt <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed load/store vectors with hand-computed
// expectations, a bus responder, and a monitor that pops expected results
// whenever the DUT completes an access or presents a bus handshake.

module tb_mem_stage_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re, mem_we, mem_uns;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        stall, misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] rdo, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  logic [33:0] exp_q[$];  // {misalign, bus_err, dram_rdo}
  logic [68:0] bus_q[$];  // {we, addr, be, wdata}

  int          ack_wait = 0;
  logic [31:0] ack_rdata = 32'h0;
  logic        force_ack = 1'b0;
  int          req_cyc = 0;
  logic        prev_stall = 1'b0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_re_i       (mem_re),
    .mem_we_i       (mem_we),
    .mem_size_i     (mem_size),
    .mem_unsigned_i (mem_uns),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .stall_o        (stall),
    .dram_rdo_o     (rdo),
    .misalign_o     (misalign),
    .bus_err_o      (bus_err),
    .bus_req_o      (bus_req),
    .bus_we_o       (bus_we),
    .bus_addr_o     (bus_addr),
    .bus_be_o       (bus_be),
    .bus_wdata_o    (bus_wdata),
    .bus_ack_i      (bus_ack),
    .bus_rdata_i    (bus_rdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  // Acks in the ack_wait-th REQ cycle (0 = never); force_ack drives a stray ack.
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus_req) req_cyc = 0;
      else req_cyc++;
      if (force_ack) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
      end else if (req_cyc != 0 && req_cyc == ack_wait) begin
        bus_ack   = 1'b1;
        bus_rdata = ack_rdata;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    logic [68:0] b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus_req && bus_ack) begin
        if (bus_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL bus_unexpected: got handshake addr %0h expected none", bus_addr);
        end else begin
          b = bus_q.pop_front();
          check("bus_cmd", {bus_we, bus_addr, bus_be, bus_wdata}, b);
        end
      end
      if (misalign || bus_err || (prev_stall && !stall)) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL result_unexpected: got rdo %0h expected none", rdo);
        end else begin
          e = exp_q.pop_front();
          check("result", {misalign, bus_err, rdo}, e);
        end
      end
      prev_stall = stall;
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input string name, input logic re, input logic we,
                           input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int wait_n, input logic [31:0] rd,
                           input int exp_stall, input int exp_req,
                           input logic [33:0] exp_res,
                           input logic has_bus, input logic [68:0] exp_bus);
    int  st, rq;
    logic done;
    if (has_bus) bus_q.push_back(exp_bus);
    exp_q.push_back(exp_res);
    @(posedge clk); #1;
    ack_wait  = wait_n;
    ack_rdata = rd;
    mem_re = re; mem_we = we; mem_size = size; mem_uns = uns;
    addr = a; wdata = wd;
    st = 0; rq = 0; done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (stall) st++;
      if (bus_req) rq++;
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_hang: got stall held 50 cycles expected release", name);
    end
    @(posedge clk); #1;
    mem_re = 1'b0; mem_we = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check({name, "_stall_cycles"}, 69'(st), 69'(exp_stall));
    check({name, "_req_cycles"}, 69'(rq), 69'(exp_req));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    mem_re = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_uns = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {stall, misalign, bus_err, bus_req, bus_we}, 69'h0);
    check("reset_rdo", rdo, 69'h0);
    check("reset_bus", {bus_addr, bus_be, bus_wdata}, 69'h0);
    check("reset_state", dbg_state, 69'h0);

    //        name     re    we    sz     u     addr          wdata         w  rdata          st rq  {mis,err,rdo}                  bus? {we,addr,be,wdata}
    do_access("lw",    1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 4, 3, {2'b00, 32'hDEAD_BEEF}, 1'b1, {1'b0, 32'h0000_0100, 4'hF, 32'h0});
    do_access("lb",    1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        1, 32'h8011_2233, 2, 1, {2'b00, 32'hFFFF_FF80}, 1'b1, {1'b0, 32'h0000_0100, 4'h8, 32'h0});
    do_access("lbu",   1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        2, 32'h8011_2233, 3, 2, {2'b00, 32'h0000_0080}, 1'b1, {1'b0, 32'h0000_0100, 4'h8, 32'h0});
    do_access("sh",    1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 1, 32'h0,        2, 1, {2'b00, 32'h0000_0080}, 1'b1, {1'b1, 32'h0000_0200, 4'hC, 32'hABCD_ABCD});
    do_access("lw_mis",1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,        1, 32'h1234_5678, 0, 0, {2'b10, 32'h0},         1'b0, 69'h0);
    do_access("lh",    1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0106, 32'h0,        1, 32'h8001_7FFF, 2, 1, {2'b00, 32'hFFFF_8001}, 1'b1, {1'b0, 32'h0000_0104, 4'hC, 32'h0});
    do_access("lhu",   1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0104, 32'h0,        2, 32'h8001_7FFF, 3, 2, {2'b00, 32'h0000_7FFF}, 1'b1, {1'b0, 32'h0000_0104, 4'h3, 32'h0});
    do_access("sb_rw", 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'h1234_5678, 1, 32'hFFFF_FFFF, 2, 1, {2'b00, 32'h0000_7FFF}, 1'b1, {1'b1, 32'h0000_0300, 4'h2, 32'h7878_7878});
    do_access("lh_mis",1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0,        1, 32'h1234_5678, 0, 0, {2'b10, 32'h0},         1'b0, 69'h0);
    do_access("lb2",   1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0,        1, 32'h00C3_0000, 2, 1, {2'b00, 32'hFFFF_FFC3}, 1'b1, {1'b0, 32'h0000_0000, 4'h4, 32'h0});
    do_access("lw_to", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0,        0, 32'h0,        5, 4, {2'b01, 32'h0},         1'b0, 69'h0);
    do_access("lw_rec",1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,        1, 32'h0BAD_F00D, 2, 1, {2'b00, 32'h0BAD_F00D}, 1'b1, {1'b0, 32'h0000_0008, 4'hF, 32'h0});
    do_access("lw_sz3",1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,        2, 32'h1122_3344, 3, 2, {2'b00, 32'h1122_3344}, 1'b1, {1'b0, 32'h0000_0010, 4'hF, 32'h0});

    // Stray ack while idle must not disturb anything.
    @(posedge clk); #1 force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_ack_ctrl", {stall, bus_req, misalign, bus_err}, 69'h0);
    check("stray_ack_rdo", rdo, 69'h1122_3344);
    @(posedge clk); #1 force_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a REQ phase.
    #1;
    ack_wait = 0;
    mem_re = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_uns = 1'b0; addr = 32'h0000_0020;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_req", {bus_req, stall}, 69'h3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {bus_req, stall}, 69'h0);
    check("async_rst_rdo", rdo, 69'h0);
    mem_re = 1'b0; addr = 32'h0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", dbg_state, 69'h0);
    do_access("lw_rst",1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0,        1, 32'h55AA_55AA, 2, 1, {2'b00, 32'h55AA_55AA}, 1'b1, {1'b0, 32'h0000_0024, 4'hF, 32'h0});

    repeat (3) @(negedge clk);
    check("exp_q_drained", 69'(exp_q.size()), 69'h0);
    check("bus_q_drained", 69'(bus_q.size()), 69'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
